// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester byte-memory sequencer.
package mem_arbiter_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_ACK     = 3'd5
  } state_e;

  // Operation captured from the winning requester at grant time.
  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_op_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer moves past a requester once its access completes.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic [1:0] gnt_c
);

  logic rr_ptr;

  // Pointer only matters when both requesters contend.
  always_comb begin
    gnt_c = 2'b00;
    case (req)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = rr_ptr ? 2'b10 : 2'b01;
      default: gnt_c = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 1'b0;
    end else if (done) begin
      rr_ptr <= ~done_id;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two byte requesters onto a level-sensitive memory with a setup/strobe/hold write sequence.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned NUM_REQ       = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] we,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [DATA_W-1:0]  wdata0,
  input  logic [DATA_W-1:0]  wdata1,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] ack,
  output logic [DATA_W-1:0]  rdata,
  output logic [DATA_W-1:0]  mem_data,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_store,
  input  logic [DATA_W-1:0]  mem_q
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  mem_op_t            cur_q, cur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               store_q, store_d;

  logic [1:0]         arb_gnt;
  mem_op_t            req_op;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .done    (state_q == ST_ACK),
    .done_id (gnt_q[1]),
    .gnt_c   (arb_gnt)
  );

  assign req_op = arb_gnt[1] ? {we[1], addr1, wdata1} : {we[0], addr0, wdata0};

  // Next-state and next-output logic; every output leaves through a flop.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    store_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = arb_gnt;
          cur_d   = req_op;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        case (cur_q.op)
          OP_WRITE: begin
            store_d = 1'b1;
            cnt_d   = CNT_W'(STROBE_CYCLES - 1);
            state_d = ST_STROBE;
          end
          OP_READ:  state_d = ST_CAPTURE;
          default:  state_d = ST_CAPTURE;
        endcase
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          store_d = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        ack_d   = gnt_q;
        state_d = ST_ACK;
      end
      ST_CAPTURE: begin
        rdata_d = mem_q;
        ack_d   = gnt_q;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_data  = cur_q.data;
  assign mem_addr  = cur_q.addr;
  assign mem_store = store_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses a 1-cycle strobe, instance 1 a 3-cycle strobe.
module tb_mem_arbiter;

  localparam int unsigned S0 = 1;
  localparam int unsigned S1 = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [1:0][1:0] req, we, addr0, addr1, gnt, ack, mem_addr;
  logic [1:0][7:0] wdata0, wdata1, rdata, mem_data, mem_q;
  logic [1:0]      mem_store;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] m [4] = '{default: 8'h00};

    mem_arbiter #(.STROBE_CYCLES(g == 0 ? S0 : S1), .NUM_REQ(2)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req[g]),
      .we        (we[g]),
      .addr0     (addr0[g]),
      .addr1     (addr1[g]),
      .wdata0    (wdata0[g]),
      .wdata1    (wdata1[g]),
      .gnt       (gnt[g]),
      .ack       (ack[g]),
      .rdata     (rdata[g]),
      .mem_data  (mem_data[g]),
      .mem_addr  (mem_addr[g]),
      .mem_store (mem_store[g]),
      .mem_q     (mem_q[g])
    );

    // Byte storage: written while store is high, read combinationally.
    always @(negedge clk) if (mem_store[g]) m[mem_addr[g]] <= mem_data[g];
    assign mem_q[g] = m[mem_addr[g]];
  end

  typedef struct {
    int         id;
    int         lat;
    int         stores;
    logic [1:0] a;
    logic [7:0] d;
    bit         chk_rd;
    logic [7:0] rd;
  } exp_t;

  typedef struct {
    int         wait_c;
    int         id;
    int         lat;
    int         stores;
    int         unstable;
    logic [1:0] sa;
    logic [7:0] sd;
    logic [7:0] rd;
    logic [1:0] ackv;
    logic [1:0] idle_gnt;
  } obs_t;

  typedef struct {
    logic [1:0] r, w, a0, a1;
    logic [7:0] d0, d1;
    exp_t       e;
  } vec_t;

  int passed = 0;
  int total  = 0;

  // Transaction-level reference: who wins, how long it takes, what memory holds.
  int         m_ptr;
  logic [7:0] m_mem [4];
  bit         m_val [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_txn(input logic [1:0] r, input logic [1:0] w, input logic [1:0] a0,
                           input logic [1:0] a1, input logic [7:0] d0, input logic [7:0] d1,
                           input int unsigned s, output exp_t e);
    int win;
    win = (r == 2'b11) ? m_ptr : (r[1] ? 1 : 0);
    e.id     = win;
    e.a      = (win == 1) ? a1 : a0;
    e.d      = (win == 1) ? d1 : d0;
    e.lat    = w[win] ? 3 + int'(s) : 3;
    e.stores = w[win] ? int'(s) : 0;
    e.chk_rd = !w[win] && m_val[e.a];
    e.rd     = m_mem[e.a];
    if (w[win]) begin
      m_mem[e.a] = e.d;
      m_val[e.a] = 1'b1;
    end
    m_ptr = 1 - win;
  endtask

  task automatic drive(input int d, input logic [1:0] r, input logic [1:0] w, input logic [1:0] a0,
                       input logic [1:0] a1, input logic [7:0] d0, input logic [7:0] d1);
    req[d] = r; we[d] = w; addr0[d] = a0; addr1[d] = a1; wdata0[d] = d0; wdata1[d] = d1;
  endtask

  // Called at a negedge in IDLE after inputs are set; returns at the negedge of the following IDLE cycle.
  task automatic observe(input int d, input bit drop, input bit scramble, output obs_t o);
    o = '{wait_c: 0, id: -1, lat: 0, stores: 0, unstable: 0, sa: 2'b00, sd: 8'h00, rd: 8'h00,
          ackv: 2'b00, idle_gnt: 2'b11};
    while (gnt[d] == 2'b00 && o.wait_c < 16) begin
      @(negedge clk);
      o.wait_c++;
    end
    if (gnt[d] == 2'b00) return;
    o.id = (gnt[d] == 2'b01) ? 0 : (gnt[d] == 2'b10) ? 1 : -2;
    o.sa = mem_addr[d];
    o.sd = mem_data[d];
    if (drop && o.id >= 0) req[d][o.id] = 1'b0;
    o.lat = 1;
    while (ack[d] == 2'b00 && o.lat < 32) begin
      if (mem_store[d]) begin
        o.stores++;
        if (scramble) begin
          wdata0[d] = ~wdata0[d];
          wdata1[d] = ~wdata1[d];
          addr0[d]  = addr0[d] + 2'd1;
          addr1[d]  = addr1[d] + 2'd1;
          we[d]     = ~we[d];
        end
      end
      @(negedge clk);
      o.lat++;
      if (mem_addr[d] !== o.sa || mem_data[d] !== o.sd) o.unstable++;
    end
    o.ackv = ack[d] & gnt[d];
    o.rd   = rdata[d];
    @(negedge clk);
    o.idle_gnt = gnt[d];
  endtask

  task automatic check_txn(input string tag, input obs_t o, input exp_t e);
    check({tag, " grant_wait"}, o.wait_c, 1);
    check({tag, " winner"}, o.id, e.id);
    check({tag, " latency"}, o.lat, e.lat);
    check({tag, " store_cycles"}, o.stores, e.stores);
    check({tag, " mem_unstable"}, o.unstable, 0);
    check({tag, " mem_addr"}, o.sa, e.a);
    check({tag, " mem_data"}, o.sd, e.d);
    check({tag, " ack_onehot"}, o.ackv, (e.id == 1) ? 2'b10 : 2'b01);
    check({tag, " gnt_dropped"}, o.idle_gnt, 2'b00);
    if (e.chk_rd) check({tag, " rdata"}, o.rd, e.rd);
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, " gnt"}, gnt[d], 0);
    check({tag, " ack"}, ack[d], 0);
    check({tag, " rdata"}, rdata[d], 0);
    check({tag, " mem_data"}, mem_data[d], 0);
    check({tag, " mem_addr"}, mem_addr[d], 0);
    check({tag, " mem_store"}, mem_store[d], 0);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      m_mem[i] = 8'h00;
      m_val[i] = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [8];
    obs_t o;
    exp_t e;
    exp_t dummy;
    logic [1:0] r, w;

    req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    model_reset();

    // Reset state, then idle with no requests.
    repeat (3) @(negedge clk);
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d gnt", i), gnt[0], 0);
      check($sformatf("idle%0d store", i), mem_store[0], 0);
    end

    // Hand-derived vectors, starting with rr_ptr at requester 0.
    tbl[0] = '{r: 2'b01, w: 2'b01, a0: 2'd2, a1: 2'd0, d0: 8'hA5, d1: 8'h00,
               e: '{id: 0, lat: 4, stores: 1, a: 2'd2, d: 8'hA5, chk_rd: 0, rd: 8'h00}};
    tbl[1] = '{r: 2'b10, w: 2'b00, a0: 2'd0, a1: 2'd2, d0: 8'h00, d1: 8'h3C,
               e: '{id: 1, lat: 3, stores: 0, a: 2'd2, d: 8'h3C, chk_rd: 1, rd: 8'hA5}};
    tbl[2] = '{r: 2'b11, w: 2'b11, a0: 2'd0, a1: 2'd1, d0: 8'h11, d1: 8'h22,
               e: '{id: 0, lat: 4, stores: 1, a: 2'd0, d: 8'h11, chk_rd: 0, rd: 8'h00}};
    tbl[3] = '{r: 2'b11, w: 2'b11, a0: 2'd0, a1: 2'd1, d0: 8'h11, d1: 8'h22,
               e: '{id: 1, lat: 4, stores: 1, a: 2'd1, d: 8'h22, chk_rd: 0, rd: 8'h00}};
    tbl[4] = '{r: 2'b01, w: 2'b00, a0: 2'd0, a1: 2'd3, d0: 8'hE7, d1: 8'h00,
               e: '{id: 0, lat: 3, stores: 0, a: 2'd0, d: 8'hE7, chk_rd: 1, rd: 8'h11}};
    tbl[5] = '{r: 2'b10, w: 2'b00, a0: 2'd0, a1: 2'd1, d0: 8'h00, d1: 8'h5C,
               e: '{id: 1, lat: 3, stores: 0, a: 2'd1, d: 8'h5C, chk_rd: 1, rd: 8'h22}};
    tbl[6] = '{r: 2'b11, w: 2'b00, a0: 2'd3, a1: 2'd2, d0: 8'h01, d1: 8'h02,
               e: '{id: 0, lat: 3, stores: 0, a: 2'd3, d: 8'h01, chk_rd: 1, rd: 8'h00}};
    tbl[7] = '{r: 2'b11, w: 2'b01, a0: 2'd3, a1: 2'd2, d0: 8'h01, d1: 8'h02,
               e: '{id: 1, lat: 3, stores: 0, a: 2'd2, d: 8'h02, chk_rd: 1, rd: 8'hA5}};
    for (int i = 0; i < 8; i++) begin
      drive(0, tbl[i].r, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      model_txn(tbl[i].r, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, S0, dummy);
      observe(0, 1'b1, 1'b0, o);
      check_txn($sformatf("vec%0d", i), o, tbl[i].e);
    end

    // Move the pointer to requester 1, then reset in the middle of a strobe.
    drive(0, 2'b01, 2'b01, 2'd3, 2'd0, 8'h3C, 8'h00);
    model_txn(2'b01, 2'b01, 2'd3, 2'd0, 8'h3C, 8'h00, S0, e);
    observe(0, 1'b1, 1'b0, o);
    check_txn("pre_rst", o, e);
    drive(0, 2'b01, 2'b01, 2'd0, 2'd0, 8'hC3, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("strobe_before_rst", mem_store[0], 1);
    reset_n = 1'b0;
    #1;
    check_zero(0, "async_rst");
    req = '0;
    m_ptr = 0;
    m_val[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("no_ack_after_rst%0d", i), ack[0], 0);
    end
    drive(0, 2'b11, 2'b11, 2'd1, 2'd2, 8'h77, 8'h88);
    model_txn(2'b11, 2'b11, 2'd1, 2'd2, 8'h77, 8'h88, S0, e);
    observe(0, 1'b1, 1'b0, o);
    check_txn("post_rst_a", o, e);
    drive(0, 2'b10, 2'b11, 2'd1, 2'd2, 8'h77, 8'h88);
    model_txn(2'b10, 2'b11, 2'd1, 2'd2, 8'h77, 8'h88, S0, e);
    observe(0, 1'b1, 1'b0, o);
    check_txn("post_rst_b", o, e);
    req[0] = 2'b00;

    // Contention from reset: both requests held, grants must alternate back to back.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    drive(0, 2'b11, 2'b11, 2'd0, 2'd1, 8'h40, 8'h80);
    for (int k = 0; k < 8; k++) begin
      wdata0[0] = 8'h40 + 8'(k);
      wdata1[0] = 8'h80 + 8'(k);
      model_txn(2'b11, 2'b11, 2'd0, 2'd1, wdata0[0], wdata1[0], S0, e);
      observe(0, 1'b0, 1'b0, o);
      check_txn($sformatf("contend%0d", k), o, e);
    end
    req[0] = 2'b00;
    check("contend_mem0", g_dut[0].m[0], m_mem[0]);
    check("contend_mem1", g_dut[0].m[1], m_mem[1]);

    // Three-cycle strobe with operands disturbed after grant.
    drive(1, 2'b01, 2'b01, 2'd1, 2'd0, 8'h5A, 8'h00);
    observe(1, 1'b1, 1'b1, o);
    e = '{id: 0, lat: 6, stores: 3, a: 2'd1, d: 8'h5A, chk_rd: 0, rd: 8'h00};
    check_txn("s3_write", o, e);
    check("s3_mem_byte", g_dut[1].m[1], 8'h5A);
    drive(1, 2'b10, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00);
    observe(1, 1'b1, 1'b0, o);
    e = '{id: 1, lat: 3, stores: 0, a: 2'd1, d: 8'h00, chk_rd: 1, rd: 8'h5A};
    check_txn("s3_read", o, e);
    req[1] = 2'b00;

    // Randomized traffic against the reference.
    for (int k = 0; k < 60; k++) begin
      r = 2'($urandom_range(1, 3));
      w = 2'($urandom);
      drive(0, r, w, 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
      model_txn(r, w, addr0[0], addr1[0], wdata0[0], wdata1[0], S0, e);
      observe(0, 1'b1, 1'b0, o);
      check_txn($sformatf("rnd%0d", k), o, e);
    end
    req[0] = 2'b00;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
